// File: rtl/player_input_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : player_input_sched_pkg
// Brief   : Shared scan codes, player/direction encodings and arbiter states.
// Revision: 1.0
// ---------------------------------------------------------------------------
package player_input_sched_pkg;

  localparam logic [7:0] P1_GAS_CODE = 8'h1D;
  localparam logic [7:0] P1_UP_CODE  = 8'h24;
  localparam logic [7:0] P1_DN_CODE  = 8'h15;
  localparam logic [7:0] P2_GAS_CODE = 8'h75;
  localparam logic [7:0] P2_UP_CODE  = 8'h7D;
  localparam logic [7:0] P2_DN_CODE  = 8'h6C;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DN   = 1'b0;

  typedef enum logic [1:0] {
    KEY_GAS = 2'd0,
    KEY_UP  = 2'd1,
    KEY_DN  = 2'd2
  } key_id_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } arb_state_e;

  // Held bits are laid out {P2_DN, P2_UP, P2_GAS, P1_DN, P1_UP, P1_GAS}.
  function automatic logic [2:0] held_idx(input logic player, input key_id_e key_id);
    logic [2:0] base;
    base = player ? 3'd3 : 3'd0;
    return base + {1'b0, key_id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/player_input_sched_key_event_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : player_input_sched_key_event_decode
// Brief   : Converts the keyboard make/break stream into one decoded event.
// Revision: 1.0
// ---------------------------------------------------------------------------
module player_input_sched_key_event_decode
  import player_input_sched_pkg::*;
#(
  parameter logic [7:0] P1_GAS = P1_GAS_CODE,
  parameter logic [7:0] P1_UP  = P1_UP_CODE,
  parameter logic [7:0] P1_DN  = P1_DN_CODE,
  parameter logic [7:0] P2_GAS = P2_GAS_CODE,
  parameter logic [7:0] P2_UP  = P2_UP_CODE,
  parameter logic [7:0] P2_DN  = P2_DN_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_new,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  output logic       make,
  output logic       brk,
  output logic       player,
  output key_id_e    key_id
);

  logic       kp_q, kp_d;
  logic [7:0] code_q, code_d;
  logic       hit;
  logic       brk_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      kp_q   <= 1'b0;
      code_q <= 8'h00;
    end else begin
      kp_q   <= kp_d;
      code_q <= code_d;
    end
  end

  always_comb begin
    kp_d   = key_pressed;
    code_d = key_code;
    hit    = 1'b1;
    player = PLAYER_1;
    key_id = KEY_GAS;
    case (key_code)
      P1_GAS: begin player = PLAYER_1; key_id = KEY_GAS; end
      P1_UP:  begin player = PLAYER_1; key_id = KEY_UP;  end
      P1_DN:  begin player = PLAYER_1; key_id = KEY_DN;  end
      P2_GAS: begin player = PLAYER_2; key_id = KEY_GAS; end
      P2_UP:  begin player = PLAYER_2; key_id = KEY_UP;  end
      P2_DN:  begin player = PLAYER_2; key_id = KEY_DN;  end
      default: hit = 1'b0;
    endcase
    // A release shows up either as the level falling or as a new code while up.
    brk_raw = (kp_q && !key_pressed) || (!key_pressed && (key_code != code_q));
    make    = code_new && hit;
    brk     = !code_new && brk_raw && hit;
  end

endmodule
`default_nettype wire

// File: rtl/player_input_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : player_input_sched
// Brief   : Per-player held keys, shift-request slots and round-robin grant.
// Revision: 1.0
// ---------------------------------------------------------------------------
module player_input_sched
  import player_input_sched_pkg::*;
#(
  parameter logic [7:0] P1_GAS = P1_GAS_CODE,
  parameter logic [7:0] P1_UP  = P1_UP_CODE,
  parameter logic [7:0] P1_DN  = P1_DN_CODE,
  parameter logic [7:0] P2_GAS = P2_GAS_CODE,
  parameter logic [7:0] P2_UP  = P2_UP_CODE,
  parameter logic [7:0] P2_DN  = P2_DN_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_new,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  input  logic       race_en,
  output logic       gas_p1,
  output logic       gas_p2,
  output logic       shift_req,
  output logic       shift_player,
  output logic       shift_dir,
  input  logic       shift_ack
);

  logic       ev_make, ev_brk, ev_player;
  key_id_e    ev_key_id;
  logic [2:0] ev_idx;
  logic       new_press;
  logic       grant_player;

  logic [5:0] held_q, held_d;
  logic [1:0] pend_valid_q, pend_valid_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  arb_state_e state_q, state_d;
  logic       req_player_q, req_player_d;
  logic       req_dir_q, req_dir_d;
  logic       last_grant_q, last_grant_d;

  player_input_sched_key_event_decode #(
    .P1_GAS (P1_GAS),
    .P1_UP  (P1_UP),
    .P1_DN  (P1_DN),
    .P2_GAS (P2_GAS),
    .P2_UP  (P2_UP),
    .P2_DN  (P2_DN)
  ) key_event_decode (
    .clk         (clk),
    .reset       (reset),
    .code_new    (code_new),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .make        (ev_make),
    .brk         (ev_brk),
    .player      (ev_player),
    .key_id      (ev_key_id)
  );

  assign ev_idx = held_idx(ev_player, ev_key_id);

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q       <= '0;
      pend_valid_q <= '0;
      pend_dir_q   <= '0;
      state_q      <= ST_IDLE;
      req_player_q <= PLAYER_1;
      req_dir_q    <= DIR_DN;
      last_grant_q <= PLAYER_2;
    end else begin
      held_q       <= held_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      state_q      <= state_d;
      req_player_q <= req_player_d;
      req_dir_q    <= req_dir_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    held_d = held_q;
    if (ev_make) begin
      held_d[ev_idx] = 1'b1;
    end else if (ev_brk) begin
      held_d[ev_idx] = 1'b0;
    end
  end

  // Only the first make of a held shift key counts; typematic repeats are dropped.
  assign new_press = ev_make && (ev_key_id != KEY_GAS) && race_en && !held_q[ev_idx];

  always_comb begin
    state_d      = state_q;
    req_player_d = req_player_q;
    req_dir_d    = req_dir_q;
    last_grant_d = last_grant_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    grant_player = (&pend_valid_q) ? ~last_grant_q : pend_valid_q[PLAYER_2];

    case (state_q)
      ST_IDLE: begin
        if (race_en && (|pend_valid_q)) begin
          req_player_d               = grant_player;
          req_dir_d                  = pend_dir_q[grant_player];
          pend_valid_d[grant_player] = 1'b0;
          state_d                    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (shift_ack) begin
          last_grant_d = req_player_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!race_en) begin
      pend_valid_d = '0;
    end
    // A same-cycle press refills the slot that the grant just emptied.
    if (new_press) begin
      pend_valid_d[ev_player] = 1'b1;
      pend_dir_d[ev_player]   = (ev_key_id == KEY_UP) ? DIR_UP : DIR_DN;
    end
  end

  assign gas_p1       = held_q[held_idx(PLAYER_1, KEY_GAS)];
  assign gas_p2       = held_q[held_idx(PLAYER_2, KEY_GAS)];
  assign shift_req    = (state_q == ST_REQ);
  assign shift_player = shift_req & req_player_q;
  assign shift_dir    = shift_req & req_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_player_input_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_player_input_sched
// Brief   : Scoreboard bench for keyboard decode, pending slots and arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_player_input_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_new;
  logic       key_pressed;
  logic [7:0] key_code;
  logic       race_en;
  logic       gas_p1, gas_p2;
  logic       shift_req, shift_player, shift_dir;
  logic       shift_ack;

  typedef struct packed {
    logic player;
    logic dir;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xfers  = 0;
  int   base;

  always #5 clk = ~clk;

  player_input_sched dut (
    .clk          (clk),
    .reset        (reset),
    .code_new     (code_new),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .race_en      (race_en),
    .gas_p1       (gas_p1),
    .gas_p2       (gas_p2),
    .shift_req    (shift_req),
    .shift_player (shift_player),
    .shift_dir    (shift_dir),
    .shift_ack    (shift_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every accepted transfer must match the oldest expected request.
  always @(negedge clk) begin
    if (!reset && shift_req && shift_ack) begin
      n_xfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'd1, 32'd0);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        check("req_player", {31'd0, shift_player}, {31'd0, e.player});
        check("req_dir", {31'd0, shift_dir}, {31'd0, e.dir});
      end
    end
  end

  task automatic push_exp(input logic player, input logic dir);
    req_t e;
    e.player = player;
    e.dir    = dir;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [7:0] c);
    @(posedge clk); #1;
    key_code    = c;
    key_pressed = 1'b1;
    code_new    = 1'b1;
    @(posedge clk); #1;
    code_new = 1'b0;
  endtask

  task automatic release_key(input logic [7:0] c);
    @(posedge clk); #1;
    key_code    = c;
    key_pressed = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!shift_req && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("req_timeout", {31'd0, shift_req}, 32'd1);
  endtask

  task automatic ack_pulse();
    wait_req();
    shift_ack = 1'b1;
    @(posedge clk); #1;
    shift_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    code_new    = 1'b0;
    key_pressed = 1'b0;
    key_code    = 8'h00;
    race_en     = 1'b1;
    shift_ack   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {27'd0, gas_p1, gas_p2, shift_req, shift_player, shift_dir}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Single P1 up: request appears two cycles after the make, for one cycle with ack high.
    push_exp(1'b0, 1'b1);
    press(8'h24);
    @(negedge clk);
    check("t1_req_n1", {31'd0, shift_req}, 32'd0);
    @(negedge clk);
    check("t1_req_n2", {31'd0, shift_req}, 32'd1);
    @(negedge clk);
    check("t1_req_n3", {31'd0, shift_req}, 32'd0);
    release_key(8'h24);
    idle(3);

    // Typematic repeats yield one request; a fresh press after release yields another.
    base = n_xfers;
    push_exp(1'b0, 1'b1);
    press(8'h24);
    press(8'h24);
    press(8'h24);
    idle(6);
    check("t2_one_req", n_xfers - base, 32'd1);
    release_key(8'h24);
    push_exp(1'b0, 1'b1);
    press(8'h24);
    idle(6);
    check("t2_second_req", n_xfers - base, 32'd2);
    release_key(8'h24);

    // P2 arrives first and is served first; P1 follows after ack.
    shift_ack = 1'b0;
    push_exp(1'b1, 1'b1);
    press(8'h7D);
    push_exp(1'b0, 1'b0);
    press(8'h15);
    wait_req();
    check("t3_first_p2", {31'd0, shift_player}, 32'd1);
    ack_pulse();
    ack_pulse();
    release_key(8'h15);
    release_key(8'h7D);
    idle(2);

    // Simultaneous pending slots alternate P1, P2, P1, P2.
    push_exp(1'b0, 1'b1);
    push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b0);
    push_exp(1'b1, 1'b1);
    press(8'h24);
    wait_req();
    press(8'h6C);
    press(8'h15);
    ack_pulse();
    wait_req();
    press(8'h7D);
    ack_pulse();
    ack_pulse();
    ack_pulse();
    release_key(8'h24);
    release_key(8'h6C);
    release_key(8'h15);
    release_key(8'h7D);
    idle(2);
    check("t3_all_served", exp_q.size(), 32'd0);

    // Gas keys follow make/break regardless of race_en; shifts are blocked when disabled.
    shift_ack = 1'b1;
    press(8'h1D);
    @(negedge clk);
    check("t4_gas_p1_on", {31'd0, gas_p1}, 32'd1);
    release_key(8'h1D);
    @(negedge clk);
    check("t4_gas_p1_off", {31'd0, gas_p1}, 32'd0);
    race_en = 1'b0;
    base    = n_xfers;
    press(8'h75);
    @(negedge clk);
    check("t4_gas_p2_on", {31'd0, gas_p2}, 32'd1);
    press(8'h7D);
    idle(5);
    check("t4_no_req", {31'd0, shift_req}, 32'd0);
    check("t4_no_xfer", n_xfers - base, 32'd0);
    release_key(8'h7D);
    release_key(8'h75);
    @(negedge clk);
    check("t4_gas_p2_off", {31'd0, gas_p2}, 32'd0);
    race_en = 1'b1;
    idle(2);

    // UP then DN before the grant: the latest direction wins.
    shift_ack = 1'b0;
    push_exp(1'b1, 1'b1);
    press(8'h7D);
    wait_req();
    push_exp(1'b0, 1'b0);
    press(8'h24);
    press(8'h15);
    ack_pulse();
    wait_req();
    check("t5_latest_dir", {31'd0, shift_dir}, 32'd0);
    ack_pulse();
    release_key(8'h15);
    release_key(8'h24);
    release_key(8'h7D);
    idle(2);

    // Dropping race_en discards a pending slot; the in-flight request still completes.
    push_exp(1'b1, 1'b1);
    press(8'h7D);
    wait_req();
    press(8'h24);
    race_en = 1'b0;
    idle(2);
    base = n_xfers;
    ack_pulse();
    idle(5);
    check("t5_drop_no_req", {31'd0, shift_req}, 32'd0);
    race_en = 1'b1;
    idle(4);
    check("t5_drop_no_xfer", n_xfers - base, 32'd1);
    release_key(8'h24);
    release_key(8'h7D);
    idle(2);

    // Reset during REQ drops the request outright.
    push_exp(1'b0, 1'b1);
    press(8'h24);
    wait_req();
    reset       = 1'b1;
    key_pressed = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_outs", {27'd0, gas_p1, gas_p2, shift_req, shift_player, shift_dir}, 32'd0);
    exp_q.delete();
    reset     = 1'b0;
    shift_ack = 1'b1;
    base      = n_xfers;
    idle(8);
    check("t6_no_req_after", {31'd0, shift_req}, 32'd0);
    check("t6_no_xfer", n_xfers - base, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
